// File: rtl/tpm_cmd_parser.sv
// tpm_cmd_parser
//   Byte-stream front end for the TPM management block. Accepts raw TPM2
//   command frames one byte per rx handshake, validates the 10-byte big-endian
//   header (tag, commandSize, commandCode), maps the command code to a small
//   command index and extracts the TPM_SU parameter of Startup/Shutdown.
//   Exactly one result (decoded command or header error code) is presented
//   per frame on the cmd valid/ready interface.
//
//   Optional inter-byte timeout: define TPM_CMD_PARSER_TIMEOUT_EN.
//
// Ports
//   clock      in   system clock
//   reset      in   asynchronous reset, active-low
//   rx_data    in   [7:0] command byte
//   rx_valid   in   rx_data valid
//   rx_last    in   final byte of the frame
//   rx_ready   out  parser accepts a byte this cycle
//   cmd_valid  out  result available
//   cmd_ready  in   consumer takes the result
//   cmd_code   out  [29:0] command index (0 Startup .. 5 GetCapability, 6 other)
//   cmd_param  out  TPM_SU value (0 CLEAR, 1 STATE)
//   cmd_error  out  result is an error code, not a command
//   cmd_rc     out  [3:0] 1111 success, 0010 VALUE, 0011 BAD_TAG, 0100 COMMAND_SIZE
//
// States
//   IDLE  | one cycle after reset, then HDR
//   HDR   | accepting the 10 header bytes
//   PARAM | counting/inspecting parameter bytes up to commandSize
//   DRAIN | discarding bytes of a bad frame until rx_last
//   EMIT  | presenting a decoded command
//   ERR   | presenting an error code

module tpm_cmd_parser #(
    parameter int MAX_CMD_BYTES  = 4096,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic        rx_ready,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [29:0] cmd_code,
    output logic        cmd_param,
    output logic        cmd_error,
    output logic [3:0]  cmd_rc
);

    localparam logic [3:0]  RC_OK       = 4'b1111;
    localparam logic [3:0]  RC_VALUE    = 4'b0010;
    localparam logic [3:0]  RC_BAD_TAG  = 4'b0011;
    localparam logic [3:0]  RC_SIZE     = 4'b0100;
    localparam logic [31:0] MAX_SIZE    = 32'(MAX_CMD_BYTES);
    localparam logic [2:0]  IDX_SHUTDOWN = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PARAM,
        S_DRAIN,
        S_EMIT,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         tag_hi_q, tag_hi_d;
    logic [31:0]        size_q, size_d;
    logic [23:0]        code_q, code_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         su_hi_q, su_hi_d;
    logic               param_pend_q, param_pend_d;
    logic               pend_q, pend_d;
    logic [3:0]         pend_rc_q, pend_rc_d;

    logic               rx_ready_q, rx_ready_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [29:0]        cmd_code_q, cmd_code_d;
    logic               cmd_param_q, cmd_param_d;
    logic               cmd_error_q, cmd_error_d;
    logic [3:0]         cmd_rc_q, cmd_rc_d;

    logic               xfer;
    logic [CNT_W-1:0]   cnt_inc;
    logic               at_size;
    logic [3:0]         hdr_idx;
    logic [15:0]        tag_word;
    logic [31:0]        size_shift;
    logic [15:0]        su_word;
    logic               set_err;
    logic [3:0]         set_rc;
    logic               eff_pend;
    logic [3:0]         eff_rc;

`ifdef TPM_CMD_PARSER_TIMEOUT_EN
    localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES > 0);
`endif

    function automatic logic [2:0] map_code(input logic [31:0] c);
        case (c)
            32'h0000_0144: map_code = 3'd0;
            32'h0000_0145: map_code = 3'd1;
            32'h0000_0143: map_code = 3'd2;
            32'h0000_0142: map_code = 3'd3;
            32'h0000_017C: map_code = 3'd4;
            32'h0000_017A: map_code = 3'd5;
            default:       map_code = 3'd6;
        endcase
    endfunction

    assign xfer       = rx_valid & rx_ready_q;
    // counter saturates instead of wrapping on endless DRAIN streams
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    assign at_size    = (32'(cnt_inc) == size_q);
    assign hdr_idx    = cnt_q[3:0];
    assign tag_word   = {tag_hi_q, rx_data};
    assign size_shift = {size_q[23:0], rx_data};
    assign su_word    = {su_hi_q, rx_data};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tag_hi_d     = tag_hi_q;
        size_d       = size_q;
        code_d       = code_q;
        idx_d        = idx_q;
        su_hi_d      = su_hi_q;
        param_pend_d = param_pend_q;
        pend_d       = pend_q;
        pend_rc_d    = pend_rc_q;
        cmd_code_d   = cmd_code_q;
        cmd_param_d  = cmd_param_q;
        cmd_error_d  = cmd_error_q;
        cmd_rc_d     = cmd_rc_q;
        set_err      = 1'b0;
        set_rc       = RC_OK;
        eff_pend     = pend_q;
        eff_rc       = pend_rc_q;

        case (state_q)
            S_IDLE: state_d = S_HDR;

            S_HDR: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    case (hdr_idx)
                        4'd0: tag_hi_d = rx_data;
                        4'd1: begin
                            if (tag_word != 16'h8001 && tag_word != 16'h8002) begin
                                set_err = 1'b1;
                                set_rc  = RC_BAD_TAG;
                            end
                        end
                        4'd2, 4'd3, 4'd4: size_d = size_shift;
                        4'd5: begin
                            size_d = size_shift;
                            if (size_shift < 32'd10 || size_shift > MAX_SIZE) begin
                                set_err = 1'b1;
                                set_rc  = RC_SIZE;
                            end
                        end
                        4'd6, 4'd7, 4'd8: code_d = {code_q[15:0], rx_data};
                        4'd9: begin
                            idx_d = map_code({code_q, rx_data});
                            // Startup/Shutdown carry exactly one TPM_SU word
                            if (idx_d <= IDX_SHUTDOWN && size_q != 32'd12) begin
                                set_err = 1'b1;
                                set_rc  = RC_SIZE;
                            end
                        end
                        default: ;
                    endcase

                    // an earlier error in the frame always wins
                    eff_pend  = pend_q | set_err;
                    eff_rc    = pend_q ? pend_rc_q : set_rc;
                    pend_d    = eff_pend;
                    pend_rc_d = eff_rc;

                    if (hdr_idx == 4'd9) begin
                        if (eff_pend) begin
                            state_d = rx_last ? S_ERR : S_DRAIN;
                        end else if (size_q == 32'd10) begin
                            if (rx_last) begin
                                state_d = S_EMIT;
                            end else begin
                                state_d   = S_DRAIN;
                                pend_d    = 1'b1;
                                pend_rc_d = RC_SIZE;
                            end
                        end else if (rx_last) begin
                            state_d   = S_ERR;
                            pend_d    = 1'b1;
                            pend_rc_d = RC_SIZE;
                        end else begin
                            state_d = S_PARAM;
                        end
                    end else if (rx_last) begin
                        state_d = S_ERR;
                        if (!eff_pend) begin
                            pend_d    = 1'b1;
                            pend_rc_d = RC_SIZE;
                        end
                    end
                end
            end

            S_PARAM: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (idx_q <= IDX_SHUTDOWN) begin
                        if (cnt_q == CNT_W'(10)) begin
                            su_hi_d = rx_data;
                        end else if (cnt_q == CNT_W'(11)) begin
                            if (su_word == 16'h0000) begin
                                param_pend_d = 1'b0;
                            end else if (su_word == 16'h0001) begin
                                param_pend_d = 1'b1;
                            end else begin
                                set_err = 1'b1;
                                set_rc  = RC_VALUE;
                            end
                        end
                    end

                    eff_pend  = pend_q | set_err;
                    eff_rc    = pend_q ? pend_rc_q : set_rc;
                    pend_d    = eff_pend;
                    pend_rc_d = eff_rc;

                    if (rx_last) begin
                        if (at_size) begin
                            state_d = eff_pend ? S_ERR : S_EMIT;
                        end else begin
                            state_d = S_ERR;
                            if (!eff_pend) begin
                                pend_d    = 1'b1;
                                pend_rc_d = RC_SIZE;
                            end
                        end
                    end else if (at_size) begin
                        // frame is longer than it declared
                        state_d = S_DRAIN;
                        if (!eff_pend) begin
                            pend_d    = 1'b1;
                            pend_rc_d = RC_SIZE;
                        end
                    end
                end
            end

            S_DRAIN: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (rx_last) begin
                        state_d = S_ERR;
                    end
                end
            end

            S_EMIT, S_ERR: begin
                if (cmd_ready) begin
                    state_d      = S_HDR;
                    cnt_d        = '0;
                    tag_hi_d     = '0;
                    size_d       = '0;
                    code_d       = '0;
                    idx_d        = '0;
                    su_hi_d      = '0;
                    param_pend_d = 1'b0;
                    pend_d       = 1'b0;
                    pend_rc_d    = RC_OK;
                end
            end

            default: state_d = S_IDLE;
        endcase

`ifdef TPM_CMD_PARSER_TIMEOUT_EN
        tmo_d = tmo_q;
        if (state_q == S_HDR || state_q == S_PARAM || state_q == S_DRAIN) begin
            if (xfer) begin
                tmo_d = '0;
            end else if (cnt_q != '0) begin
                if (tmo_q == TMO_LAST) begin
                    state_d   = S_ERR;
                    pend_d    = 1'b1;
                    pend_rc_d = RC_SIZE;
                    tmo_d     = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        end else begin
            tmo_d = '0;
        end
`endif

        rx_ready_d  = (state_d == S_HDR) || (state_d == S_PARAM) || (state_d == S_DRAIN);
        cmd_valid_d = (state_d == S_EMIT) || (state_d == S_ERR);

        // result fields load only on entry so they stay stable while held
        if (state_d == S_EMIT && state_q != S_EMIT) begin
            cmd_code_d  = {27'd0, idx_d};
            cmd_param_d = param_pend_d;
            cmd_error_d = 1'b0;
            cmd_rc_d    = RC_OK;
        end else if (state_d == S_ERR && state_q != S_ERR) begin
            cmd_error_d = 1'b1;
            cmd_rc_d    = pend_rc_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            tag_hi_q     <= '0;
            size_q       <= '0;
            code_q       <= '0;
            idx_q        <= '0;
            su_hi_q      <= '0;
            param_pend_q <= 1'b0;
            pend_q       <= 1'b0;
            pend_rc_q    <= RC_OK;
            rx_ready_q   <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_code_q   <= '0;
            cmd_param_q  <= 1'b0;
            cmd_error_q  <= 1'b0;
            cmd_rc_q     <= RC_OK;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tag_hi_q     <= tag_hi_d;
            size_q       <= size_d;
            code_q       <= code_d;
            idx_q        <= idx_d;
            su_hi_q      <= su_hi_d;
            param_pend_q <= param_pend_d;
            pend_q       <= pend_d;
            pend_rc_q    <= pend_rc_d;
            rx_ready_q   <= rx_ready_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_code_q   <= cmd_code_d;
            cmd_param_q  <= cmd_param_d;
            cmd_error_q  <= cmd_error_d;
            cmd_rc_q     <= cmd_rc_d;
        end
    end

`ifdef TPM_CMD_PARSER_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign rx_ready  = rx_ready_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_param = cmd_param_q;
    assign cmd_error = cmd_error_q;
    assign cmd_rc    = cmd_rc_q;

endmodule

// File: doc/tpm_cmd_parser.md
Name: tpm_cmd_parser

Overview:
- Byte-stream front end that feeds management_module.
- Receives raw TPM2 command frames one byte per handshake and validates the 10-byte header: tag, commandSize and commandCode, all big-endian.
- Maps the command to the management command index (`cmd_code`, 30 bits) and extracts the TPM_SU startup/shutdown parameter (`cmd_param`).
- Presents one result per frame on a valid/ready output, either a decoded command or a header error code.

Parameters:
- MAX_CMD_BYTES, default 4096: largest legal commandSize; frames declaring more are rejected.
- CNT_W, default 16: width of the byte counter; must hold MAX_CMD_BYTES.
- TIMEOUT_CYCLES, default 1024: inter-byte timeout; used only with the optional feature.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous reset, active-low
- rx_data  in  8  command byte
- rx_valid  in  1  rx_data valid
- rx_last  in  1  marks final byte of frame
- rx_ready  out  1  parser accepts byte
- cmd_valid  out  1  result available
- cmd_ready  in  1  consumer takes result
- cmd_code  out  30  command index: 0 Startup, 1 Shutdown, 2 SelfTest, 3 IncrementalSelfTest, 4 GetTestResult, 5 GetCapability, 6 other
- cmd_param  out  1  TPM_SU value: 0 CLEAR, 1 STATE
- cmd_error  out  1  result is an error, not a command
- cmd_rc  out  4  1111 success, 0010 VALUE, 0011 BAD_TAG, 0100 COMMAND_SIZE

Behaviour:
- Reset: reset is asynchronous, active-low; clock is clock. All outputs are registered. On reset:
  - state=IDLE, rx_ready=0, cmd_valid=0, cmd_error=0
  - cmd_code=0, cmd_param=0, cmd_rc=1111
  - byte counter=0
- rx_ready:
  - 1 in HDR, PARAM and DRAIN.
  - 0 in IDLE (first cycle after reset only), EMIT and ERR.
  - A byte transfers when rx_valid & rx_ready.
- States:
  - IDLE: moves to HDR on the next cycle.
  - HDR: accepts 10 bytes.
    - Bytes 0-1 form the tag. It must be 0x8001 or 0x8002; any other value sets a pending BAD_TAG.
    - Bytes 2-5 form commandSize. Less than 10 or greater than MAX_CMD_BYTES sets a pending COMMAND_SIZE.
    - Bytes 6-9 form commandCode. Mapping: 0x144→0, 0x145→1, 0x143→2, 0x142→3, 0x17C→4, 0x17A→5, anything else→6.
  - HDR exit after byte 9:
    - Any pending error → DRAIN (ERR directly if byte 9 had rx_last).
    - commandSize==10 and rx_last → EMIT.
    - Otherwise → PARAM.
  - PARAM:
    - Counts bytes until the total equals commandSize.
    - For codes 0 and 1 with commandSize==12, bytes 10-11 are TPM_SU. Value 0x0000 → param 0; 0x0001 → param 1; any other value → pending VALUE.
    - Codes 0 and 1 with commandSize≠12 → pending COMMAND_SIZE.
    - Parameters of all other codes are discarded.
  - Size checking (first error wins; BAD_TAG has priority over COMMAND_SIZE within one header):
    - rx_last on the byte where the count equals commandSize → EMIT (or ERR if an error is pending).
    - rx_last earlier than commandSize, including inside HDR → ERR with COMMAND_SIZE.
    - Count reaches commandSize without rx_last → DRAIN; the frame ends in ERR with COMMAND_SIZE.
  - DRAIN: accepts and discards bytes until rx_last → ERR.
  - EMIT:
    - Loads cmd_code and cmd_param, sets cmd_error=0, cmd_rc=1111, cmd_valid=1.
    - Holds until cmd_ready, then cmd_valid=0 → HDR with the counter cleared.
  - ERR:
    - Sets cmd_error=1 and cmd_rc to the pending code. cmd_code and cmd_param keep their previous values.
    - cmd_valid=1; handshake as in EMIT → HDR.
- Output handshake:
  - cmd_valid rises the cycle after the last byte is accepted (1-cycle latency).
  - While cmd_valid=1 the outputs are stable and rx_ready=0 (backpressure).
  - A transfer completes on the cycle where cmd_valid & cmd_ready.
- The byte counter saturates at 2^CNT_W-1; it never wraps.
- Reset asserted mid-frame or mid-handshake: the partial frame and any pending result are discarded; no result is emitted.

Optional Feature:
- Macro: TPM_CMD_PARSER_TIMEOUT_EN.
- Defined:
  - A counter runs while in HDR/PARAM/DRAIN after the first byte of a frame, whenever no byte transfers. It clears on each transfer.
  - On reaching TIMEOUT_CYCLES: frame aborted → ERR with cmd_rc=0100.
  - Later bytes of the aborted frame start a new frame.
- Undefined: no timeout logic; the parser waits indefinitely for bytes.

Test Plan:
- Startup(CLEAR) frame 80 01 00 00 00 0C 00 00 01 44 00 00, last on byte 12, cmd_ready=1 → cmd_valid one cycle after the last byte, cmd_code=0, cmd_param=0, cmd_error=0, cmd_rc=1111.
- Shutdown(STATE) frame 80 01 00 00 00 0C 00 00 01 45 00 01 with cmd_ready held 0 for 5 cycles → cmd_code=1, cmd_param=1; cmd_valid and rx_ready=0 held stable for 5 cycles.
- Tag 80 03, otherwise valid 10-byte GetCapability frame → cmd_error=1, cmd_rc=0011, cmd_code unchanged from previous command.
- Startup frame with rx_last on byte 8 → cmd_rc=0100; next valid SelfTest frame (…01 43, size 10) → cmd_code=2, cmd_rc=1111.
- Startup with parameter 00 02 → cmd_rc=0010. Unknown code 0x0000017E, size 10 → cmd_code=6, cmd_rc=1111.
- With TPM_CMD_PARSER_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 4 header bytes then idle 16 cycles → ERR, cmd_rc=0100. Reset pulsed mid-frame → no cmd_valid, outputs at reset values.
